irig_frame_sequencer: RTL and testbench

//  Frame-level stage that sits between the IRIG-B symbol slicer and bcd_decoder.

---
 rtl/irig_frame_sequencer_pkg.sv | 46 ++++
 rtl/irig_frame_sequencer_if.sv | 20 ++
 rtl/irig_frame_sequencer_field_map.sv | 35 +++
 rtl/irig_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_irig_frame_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irig_frame_sequencer_pkg.sv
// Shared types and constants for the IRIG-B frame sequencer.
// The year field (IRIG_YEAR_EN builds) uses FLD_YEAR and YEAR_MAX from here.
`timescale 1ns/1ps
package irig_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_P    = 2'b10,
    SYM_BAD  = 2'b11
  } sym_e;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC_P,
    ST_FRAME
  } state_e;

  typedef enum logic [2:0] {
    FLD_SEC,
    FLD_MIN,
    FLD_HOUR,
    FLD_DAY,
    FLD_YEAR,
    FLD_NONE
  } field_e;

  // base is the frame position of weight bit 0 for the lane
  typedef struct packed {
    field_e     field;
    logic [1:0] digit;
    logic [6:0] base;
  } lane_t;

  localparam logic [1:0] DIGIT_NONE = 2'd3;
  localparam logic [5:0] SEC_MAX    = 6'd59;
  localparam logic [5:0] MIN_MAX    = 6'd59;
  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [8:0] DAY_MAX    = 9'd366;
  localparam logic [6:0] YEAR_MAX   = 7'd99;

  function automatic logic is_marker(input logic [6:0] pos);
    return (pos == 7'd0) || ((pos % 7'd10) == 7'd9);
  endfunction

endpackage

// File: rtl/irig_frame_sequencer_if.sv
// Symbol input and bcd_decoder link of the IRIG-B frame sequencer.
`timescale 1ns/1ps
interface irig_frame_sequencer_if;
  logic       sym_valid;
  logic [1:0] sym;
  logic [2:0] bcd_bit_idx;
  logic [1:0] bcd_digit_idx;
  logic       bcd_bit;
  logic [8:0] bcd_value;

  modport master (
    output sym_valid, sym, bcd_value,
    input  bcd_bit_idx, bcd_digit_idx, bcd_bit
  );

  modport slave (
    input  sym_valid, sym, bcd_value,
    output bcd_bit_idx, bcd_digit_idx, bcd_bit
  );
endinterface

// File: rtl/irig_frame_sequencer_field_map.sv
// Frame bit position -> field, BCD digit and weight bit.
// Year lanes (bits 50-58) exist only when IRIG_YEAR_EN is defined.
`timescale 1ns/1ps
module irig_frame_sequencer_field_map
  import irig_frame_sequencer_pkg::*;
(
  input  logic [6:0] pos,
  output field_e     field,
  output logic [2:0] bit_idx,
  output logic [1:0] digit_idx
);

  lane_t lane;

  always_comb begin
    lane = '{FLD_NONE, DIGIT_NONE, pos};
    if      (pos inside {[7'd1:7'd4]})   lane = '{FLD_SEC,  2'd0, 7'd1};
    else if (pos inside {[7'd6:7'd8]})   lane = '{FLD_SEC,  2'd1, 7'd6};
    else if (pos inside {[7'd10:7'd13]}) lane = '{FLD_MIN,  2'd0, 7'd10};
    else if (pos inside {[7'd15:7'd17]}) lane = '{FLD_MIN,  2'd1, 7'd15};
    else if (pos inside {[7'd20:7'd23]}) lane = '{FLD_HOUR, 2'd0, 7'd20};
    else if (pos inside {[7'd25:7'd26]}) lane = '{FLD_HOUR, 2'd1, 7'd25};
    else if (pos inside {[7'd30:7'd33]}) lane = '{FLD_DAY,  2'd0, 7'd30};
    else if (pos inside {[7'd35:7'd38]}) lane = '{FLD_DAY,  2'd1, 7'd35};
    else if (pos inside {[7'd40:7'd41]}) lane = '{FLD_DAY,  2'd2, 7'd40};
`ifdef IRIG_YEAR_EN
    else if (pos inside {[7'd50:7'd53]}) lane = '{FLD_YEAR, 2'd0, 7'd50};
    else if (pos inside {[7'd55:7'd58]}) lane = '{FLD_YEAR, 2'd1, 7'd55};
`endif
    field     = lane.field;
    digit_idx = lane.digit;
    bit_idx   = 3'(pos - lane.base);
  end

endmodule

// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: finds P,P sync, steers bcd_decoder, publishes time-of-year.
// Define IRIG_YEAR_EN to add the year output and its range check.
`timescale 1ns/1ps
module irig_frame_sequencer
  import irig_frame_sequencer_pkg::*;
#(
  parameter int FRAME_BITS  = 100,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irig_frame_sequencer_if.slave bus,
  output logic [5:0]            sec,
  output logic [5:0]            min,
  output logic [4:0]            hour,
  output logic [8:0]            day,
`ifdef IRIG_YEAR_EN
  output logic [6:0]            year,
`endif
  output logic                  time_valid,
  output logic                  frame_err,
  output logic                  locked
);

  state_e     state;
  logic [6:0] cnt;
  logic [5:0] sec_acc, min_acc;
  logic [4:0] hour_acc;
  logic [8:0] day_acc;
  logic       ovf;
  field_e     field;
  logic [2:0] bit_idx;
  logic [1:0] digit_idx;
  logic       is_p, sym_bad, last_bit, start_frame, accumulate, add_ovf, range_ok;
  logic [6:0] sec_sum, min_sum;
  logic [5:0] hour_sum;
  logic [9:0] day_sum;
`ifdef IRIG_YEAR_EN
  logic [6:0] year_acc;
  logic [7:0] year_sum;
`endif

  irig_frame_sequencer_field_map u_field_map (
    .pos       (cnt),
    .field     (field),
    .bit_idx   (bit_idx),
    .digit_idx (digit_idx)
  );

  assign bus.bcd_bit_idx   = bit_idx;
  assign bus.bcd_digit_idx = digit_idx;
  assign bus.bcd_bit       = (state == ST_FRAME) && (bus.sym == SYM_ONE) && (digit_idx != DIGIT_NONE);

  // Accumulators are output-width; a carry out of any add is remembered so an
  // out-of-range field cannot wrap back into range before the frame-end check.
  always_comb begin
    is_p        = (bus.sym == SYM_P);
    sym_bad     = (bus.sym == SYM_BAD) || (is_p != is_marker(cnt));
    last_bit    = (cnt == 7'(FRAME_BITS - 1));
    start_frame = bus.sym_valid && is_p &&
                  ((state == ST_SYNC_P) || ((state == ST_FRAME) && (cnt == 7'd0)));
    accumulate  = bus.sym_valid && (state == ST_FRAME) && !sym_bad && (cnt != 7'd0) && !last_bit;
    sec_sum     = {1'b0, sec_acc}  + {1'b0, bus.bcd_value[5:0]};
    min_sum     = {1'b0, min_acc}  + {1'b0, bus.bcd_value[5:0]};
    hour_sum    = {1'b0, hour_acc} + {1'b0, bus.bcd_value[4:0]};
    day_sum     = {1'b0, day_acc}  + {1'b0, bus.bcd_value};
    add_ovf     = ((field == FLD_SEC)  && sec_sum[6])  || ((field == FLD_MIN) && min_sum[6]) ||
                  ((field == FLD_HOUR) && hour_sum[5]) || ((field == FLD_DAY) && day_sum[9]);
    range_ok    = !ovf && (sec_acc <= SEC_MAX) && (min_acc <= MIN_MAX) && (hour_acc <= HOUR_MAX) &&
                  (day_acc != 9'd0) && (day_acc <= DAY_MAX);
`ifdef IRIG_YEAR_EN
    year_sum    = {1'b0, year_acc} + {1'b0, bus.bcd_value[6:0]};
    add_ovf     = add_ovf || ((field == FLD_YEAR) && year_sum[7]);
    range_ok    = range_ok && (year_acc <= YEAR_MAX);
`endif
    if (!CHECK_RANGE) range_ok = 1'b1;
  end

  // After a good bit 99 the FSM stays in FRAME with the counter at 0, so the
  // next symbol must be the P that starts the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      cnt        <= '0;
      sec_acc    <= '0;
      min_acc    <= '0;
      hour_acc   <= '0;
      day_acc    <= '0;
      ovf        <= 1'b0;
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      day        <= '0;
`ifdef IRIG_YEAR_EN
      year_acc   <= '0;
      year       <= '0;
`endif
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bus.sym_valid) begin
        case (state)
          ST_HUNT: if (is_p) state <= ST_SYNC_P;
          ST_SYNC_P: begin
            if (is_p) begin
              state  <= ST_FRAME;
              locked <= 1'b1;
              cnt    <= 7'd1;
            end else begin
              state  <= ST_HUNT;
            end
          end
          ST_FRAME: begin
            if (sym_bad) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              cnt       <= '0;
              state     <= is_p ? ST_SYNC_P : ST_HUNT;
            end else if (cnt == 7'd0) begin
              cnt <= 7'd1;
            end else if (last_bit) begin
              cnt <= '0;
              if (range_ok) begin
                sec        <= sec_acc;
                min        <= min_acc;
                hour       <= hour_acc;
                day        <= day_acc;
`ifdef IRIG_YEAR_EN
                year       <= year_acc;
`endif
                time_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                locked    <= 1'b0;
                state     <= ST_SYNC_P;
              end
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
      if (start_frame) begin
        sec_acc  <= '0;
        min_acc  <= '0;
        hour_acc <= '0;
        day_acc  <= '0;
`ifdef IRIG_YEAR_EN
        year_acc <= '0;
`endif
        ovf      <= 1'b0;
      end else if (accumulate) begin
        case (field)
          FLD_SEC:  sec_acc  <= sec_sum[5:0];
          FLD_MIN:  min_acc  <= min_sum[5:0];
          FLD_HOUR: hour_acc <= hour_sum[4:0];
          FLD_DAY:  day_acc  <= day_sum[8:0];
`ifdef IRIG_YEAR_EN
          FLD_YEAR: year_acc <= year_sum[6:0];
`endif
          default: ;
        endcase
        ovf <= ovf | add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Bench for irig_frame_sequencer with a bcd_decoder stand-in and a frame-level model.
// Honours IRIG_YEAR_EN the same way as the design.
`timescale 1ns/1ps
module tb_irig_frame_sequencer;
  import irig_frame_sequencer_pkg::*;

`ifdef IRIG_YEAR_EN
  localparam int N_LANES = 11;
`else
  localparam int N_LANES = 9;
`endif
  localparam int LANE_START [11] = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
  localparam int LANE_LEN   [11] = '{4, 3, 4,  3,  4,  2,  4,  4,  2,  4,  4};
  localparam int LANE_DIG   [11] = '{0, 1, 0,  1,  0,  1,  0,  1,  2,  0,  1};
  localparam int LANE_FLD   [11] = '{0, 0, 1,  1,  2,  2,  3,  3,  3,  4,  4};
  localparam int P10        [3]  = '{1, 10, 100};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [8:0] day;
`ifdef IRIG_YEAR_EN
  logic [6:0] year;
`endif
  logic       time_valid, frame_err, locked;

  irig_frame_sequencer_if bus_if ();

  irig_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .day        (day),
`ifdef IRIG_YEAR_EN
    .year       (year),
`endif
    .time_valid (time_valid),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // bcd_decoder stand-in: weight 2^bit scaled by 10^digit
  always_comb begin
    bus_if.bcd_value = '0;
    if (bus_if.bcd_bit && (bus_if.bcd_digit_idx != 2'd3))
      bus_if.bcd_value = 9'((1 << bus_if.bcd_bit_idx) * P10[bus_if.bcd_digit_idx]);
  end

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: tracks stream position, stores the frame's symbols, decodes at bit 99
  logic [1:0] fr [100];
  logic [1:0] fb [100];
  int  m_pos;
  bit  m_locked, m_prevp;
  int  exp_sec, exp_min, exp_hour, exp_day, exp_year;
  int  exp_tv, exp_err, exp_locked;
  int  exp_digit, exp_bitidx, exp_bcdbit;

  function automatic void lane_of(input int p, output int dig, output int bidx);
    dig  = 3;
    bidx = 0;
    for (int i = 0; i < N_LANES; i++)
      if (p >= LANE_START[i] && p < LANE_START[i] + LANE_LEN[i]) begin
        dig  = LANE_DIG[i];
        bidx = p - LANE_START[i];
      end
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_locked = 0; m_prevp = 0;
    exp_sec = 0; exp_min = 0; exp_hour = 0; exp_day = 0; exp_year = 0;
    exp_tv = 0; exp_err = 0; exp_locked = 0;
  endfunction

  function automatic void model_idle();
    exp_tv  = 0;
    exp_err = 0;
  endfunction

  function automatic void model_step(input logic [1:0] s);
    int  f [5];
    int  v, d, b;
    bit  marker, ok;
    lane_of(m_locked ? m_pos : 0, d, b);
    exp_digit  = d;
    exp_bitidx = b;
    exp_bcdbit = (m_locked && s == SYM_ONE && d != 3) ? 1 : 0;
    exp_tv  = 0;
    exp_err = 0;
    if (!m_locked) begin
      if (s == SYM_P && m_prevp) begin
        m_locked = 1; fr[0] = s; m_pos = 1;
      end else begin
        m_prevp = (s == SYM_P);
      end
    end else begin
      marker = (m_pos == 0) || (m_pos % 10 == 9);
      if (s == SYM_BAD || ((s == SYM_P) != marker)) begin
        exp_err = 1; m_locked = 0; m_prevp = (s == SYM_P); m_pos = 0;
      end else begin
        fr[m_pos] = s;
        if (m_pos == 99) begin
          foreach (f[k]) f[k] = 0;
          for (int i = 0; i < N_LANES; i++) begin
            v = 0;
            for (int j = 0; j < LANE_LEN[i]; j++)
              if (fr[LANE_START[i] + j] == SYM_ONE) v += (1 << j);
            f[LANE_FLD[i]] += v * P10[LANE_DIG[i]];
          end
          ok = (f[0] <= 59) && (f[1] <= 59) && (f[2] <= 23) && (f[3] >= 1) && (f[3] <= 366) &&
               ((N_LANES < 11) || (f[4] <= 99));
          m_pos = 0;
          if (ok) begin
            exp_sec = f[0]; exp_min = f[1]; exp_hour = f[2]; exp_day = f[3]; exp_year = f[4];
            exp_tv  = 1;
          end else begin
            exp_err = 1; m_locked = 0; m_prevp = 1;
          end
        end else begin
          m_pos++;
        end
      end
    end
    exp_locked = m_locked;
  endfunction

  // Encoder: decimal time -> 100-symbol frame (year lanes always filled)
  task automatic build_frame(input int s, input int mi, input int h, input int d, input int y);
    int val [5];
    int dv;
    val = '{s, mi, h, d, y};
    for (int p = 0; p < 100; p++) fb[p] = (p == 0 || p % 10 == 9) ? SYM_P : SYM_ZERO;
    for (int i = 0; i < 11; i++) begin
      dv = (val[LANE_FLD[i]] / P10[LANE_DIG[i]]) % 10;
      for (int j = 0; j < LANE_LEN[i]; j++)
        if (dv[j]) fb[LANE_START[i] + j] = SYM_ONE;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] s);
    @(negedge clk);
    bus_if.sym_valid = 1'b1;
    bus_if.sym       = s;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.sym_valid = 1'b0;
      bus_if.sym       = SYM_ZERO;
      model_idle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) apply_stimulus(fb[p]);
  endtask

  task automatic sync_and_send();
    apply_stimulus(SYM_ZERO);
    apply_stimulus(SYM_P);
    send_range(0, 99);
  endtask

  task automatic check_time(input string tag, input int s, input int mi, input int h, input int d);
    check_output({tag, "_sec"},  sec,  s);
    check_output({tag, "_min"},  min,  mi);
    check_output({tag, "_hour"}, hour, h);
    check_output({tag, "_day"},  day,  d);
  endtask

  // Cycle compare: registered outputs after each edge, index outputs mid-cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_output("sec",        sec,        exp_sec);
      check_output("min",        min,        exp_min);
      check_output("hour",       hour,       exp_hour);
      check_output("day",        day,        exp_day);
`ifdef IRIG_YEAR_EN
      check_output("year",       year,       exp_year);
`endif
      check_output("time_valid", time_valid, exp_tv);
      check_output("frame_err",  frame_err,  exp_err);
      check_output("locked",     locked,     exp_locked);
      @(negedge clk);
      #2;
      if (bus_if.sym_valid && rst_n) begin
        check_output("bcd_digit_idx", bus_if.bcd_digit_idx, exp_digit);
        check_output("bcd_bit_idx",   bus_if.bcd_bit_idx,   exp_bitidx);
        check_output("bcd_bit",       bus_if.bcd_bit,       exp_bcdbit);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_if.sym_valid = 1'b0;
    bus_if.sym       = SYM_ZERO;
    model_reset();
    #1 rst_n = 1'b0;
    idle(3);
    check_output("reset_locked", locked, 0);
    check_output("reset_tv",     time_valid, 0);
    check_time("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_idle();
    @(posedge clk);
    #1;

    $display("[TB] clean frame 23:59:58 day 366");
    build_frame(58, 59, 23, 366, 24);
    apply_stimulus(SYM_P);
    send_range(0, 99);
    check_output("t1_tv",     time_valid, 1);
    check_output("t1_locked", locked, 1);
    check_time("t1", 58, 59, 23, 366);
`ifdef IRIG_YEAR_EN
    check_output("t1_year", year, 24);
`endif
    idle(1);
    check_output("t1_tv_drop", time_valid, 0);

    $display("[TB] random data then P,P");
    for (int i = 0; i < 40; i++) apply_stimulus(2'($urandom_range(0, 1)));
    check_output("t2_unlocked", locked, 0);
    build_frame(1, 0, 0, 1, 0);
    apply_stimulus(SYM_P);
    check_output("t2_first_p", locked, 0);
    send_range(0, 0);
    check_output("t2_second_p", locked, 1);
    send_range(1, 99);
    check_output("t2_tv", time_valid, 1);
    check_time("t2", 1, 0, 0, 1);

    $display("[TB] marker at bit 37");
    build_frame(56, 34, 12, 123, 7);
    fb[37] = SYM_P;
    apply_stimulus(SYM_ZERO);
    apply_stimulus(SYM_P);
    send_range(0, 37);
    check_output("t3_err",    frame_err, 1);
    check_output("t3_locked", locked, 0);
    check_output("t3_tv",     time_valid, 0);
    check_time("t3_held", 1, 0, 0, 1);
    idle(2);
    build_frame(56, 34, 12, 123, 7);
    sync_and_send();
    check_time("t3_resync", 56, 34, 12, 123);

    $display("[TB] invalid symbol at bit 12, ONE at index bit 5");
    build_frame(7, 0, 0, 200, 0);
    fb[12] = SYM_BAD;
    apply_stimulus(SYM_ZERO);
    apply_stimulus(SYM_P);
    send_range(0, 12);
    check_output("t4_err",    frame_err, 1);
    check_output("t4_locked", locked, 0);
    build_frame(7, 0, 0, 200, 0);
    fb[5] = SYM_ONE;
    sync_and_send();
    check_output("t4_tv", time_valid, 1);
    check_time("t4", 7, 0, 0, 200);

    $display("[TB] reset mid-frame");
    build_frame(30, 20, 10, 45, 99);
    apply_stimulus(SYM_ZERO);
    apply_stimulus(SYM_P);
    send_range(0, 49);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.sym_valid = 1'b0;
    model_reset();
    #1;
    check_output("t5_locked", locked, 0);
    check_time("t5_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    model_idle();
    @(posedge clk);
    #1;
    sync_and_send();
    check_time("t5", 30, 20, 10, 45);

    $display("[TB] seconds field 70");
    build_frame(70, 20, 10, 45, 99);
    sync_and_send();
    check_output("t6_err", frame_err, 1);
    check_output("t6_tv",  time_valid, 0);
    check_time("t6_held", 30, 20, 10, 45);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
